// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request/response, prefetch FIFO, HALT detect.
// Optional consumer-accept counter (fetch_count) enabled by defining FETCH_PERF_EN.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
`ifdef FETCH_PERF_EN
  output logic [15:0]       fetch_count,
`endif
  output logic              halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;

  state_t            state, state_nxt;
  logic              drop, drop_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;

  logic [15:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    pc_nxt    = pc;
    push      = 1'b0;
    imem_req  = 1'b0;
    pop       = (count != '0) && instr_ready && !redirect;
    if (redirect) begin
      pc_nxt = redirect_addr;
      // A still-pending response must be swallowed; one arriving this cycle is already dropped.
      if (state == S_WAIT && !imem_rvalid) begin
        state_nxt = S_WAIT;
        drop_nxt  = 1'b1;
      end else begin
        state_nxt = S_IDLE;
        drop_nxt  = 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (en && count < DEPTH_C) begin
            imem_req  = 1'b1;
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = S_IDLE;
            end else if (imem_rdata[15:12] == 4'b1111) begin
              state_nxt = S_HALT;
            end else begin
              push      = 1'b1;
              pc_nxt    = pc + ADDR_W'(1);
              state_nxt = S_IDLE;
            end
          end
        end
        S_HALT: ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      drop  <= 1'b0;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= imem_rdata;
  end

  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? mem[rd_ptr] : 16'h0000;
  assign halted      = (state == S_HALT);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (pop && fetch_count != 16'hFFFF) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every cycle plus directed scenarios.
module tb_instr_fetch_unit;
  localparam int          ADDR_W   = 8;
  localparam int          DEPTH    = 4;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst, en, imem_rvalid, instr_ready, redirect;
  logic [7:0]  redirect_addr;
  logic [15:0] imem_rdata;
  logic        imem_req, instr_valid, halted;
  logic [7:0]  imem_addr;
  logic [15:0] instr;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_addr(redirect_addr),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Instruction memory: word = 0x1000 + addr, except a HALT word at halt_addr; latency lat cycles
  int         lat = 1;
  int         halt_addr = -1;
  bit         pend = 1'b0;
  int         pend_cnt = 0;
  logic [7:0] pend_addr;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    if (int'(a) == halt_addr) return 16'hF000;
    return 16'h1000 + {8'h00, a};
  endfunction

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end
    end
  end

  // Reference model: FIFO contents as a queue, plus PC and flags
  logic [15:0] m_q[$];
  logic [7:0]  m_pc;
  bit          m_busy, m_drop, m_halt, m_req_now;
  int          m_acc;

  function automatic bit m_req();
    return !m_busy && !m_halt && en && !redirect && (m_q.size() < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pc = RESET_PC; m_busy = 0; m_drop = 0; m_halt = 0; m_acc = 0;
    end else begin
      m_req_now = m_req();
      if (redirect) begin
        m_q.delete();
        m_pc   = redirect_addr;
        m_halt = 0;
        if (m_busy && !imem_rvalid) m_drop = 1;
        else begin m_busy = 0; m_drop = 0; end
      end else begin
        if (m_q.size() > 0 && instr_ready) begin
          void'(m_q.pop_front());
          m_acc++;
        end
        if (m_busy && imem_rvalid) begin
          m_busy = 0;
          if (m_drop) m_drop = 0;
          else if (imem_rdata[15:12] == 4'hF) m_halt = 1;
          else begin m_q.push_back(imem_rdata); m_pc = m_pc + 8'd1; end
        end
        if (m_req_now) m_busy = 1;
      end
    end
  end

  logic [15:0] got_q[$];
  logic [7:0]  addr_q[$];
  bit          e_req;
  logic [15:0] e_instr;

  always @(negedge clk) begin
    if (!rst) begin
      e_req   = m_req();
      e_instr = 16'h0000;
      if (m_q.size() > 0) e_instr = m_q[0];
      chk("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", instr_valid, m_q.size() > 0);
      chk("instr", instr, e_instr);
      chk("halted", halted, m_halt);
`ifdef FETCH_PERF_EN
      chk("fetch_count", fetch_count, m_acc);
`endif
      if (instr_valid && instr_ready && !redirect) got_q.push_back(instr);
      if (imem_req) begin
        addr_q.push_back(imem_addr);
        pend = 1'b1; pend_cnt = lat; pend_addr = imem_addr;
      end
    end
  end

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return {16'h0, got_q[i]};
    return 32'hDEAD0000;
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    if (i < addr_q.size()) return {24'h0, addr_q[i]};
    return 32'hDEAD0000;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic flush(input logic [7:0] a);
    redirect = 1'b1; redirect_addr = a;
    cyc(1);
    redirect = 1'b0;
  endtask

  task automatic clearq();
    got_q.delete(); addr_q.delete();
  endtask

  task automatic wait_req(input logic [7:0] a, input string name);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) found = 1;
    end
    chk(name, found, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 0; en = 0; instr_ready = 0; redirect = 0; redirect_addr = 0;
    imem_rvalid = 0; imem_rdata = 0;
    #2 rst = 1;
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // in-order delivery, latency 1
    clearq(); en = 1; instr_ready = 1;
    cyc(12);
    for (int i = 0; i < 3; i++) begin
      chk("t1_instr", got_at(i), 32'h1000 + i);
      chk("t1_addr", addr_at(i), i);
    end
    en = 0; cyc(4);

    // consumer stalled: FIFO fills with exactly DEPTH requests
    instr_ready = 0; flush(8'h00); clearq(); en = 1;
    cyc(20);
    chk("t2_reqs", addr_q.size(), 4);
    chk("t2_valid", instr_valid, 1);
    chk("t2_head", instr, 16'h1000);
    instr_ready = 1; cyc(1); instr_ready = 0; cyc(5);
    chk("t2_reqs_after_pop", addr_q.size(), 5);
    chk("t2_addr4", addr_at(4), 4);

    // redirect while a 3-cycle request is outstanding
    en = 0; instr_ready = 1; cyc(3);
    flush(8'h00); lat = 3; clearq(); en = 1;
    wait_req(8'h02, "t3_req2_seen");
    @(posedge clk); #1;
    redirect = 1; redirect_addr = 8'h40; clearq();
    cyc(1); redirect = 0;
    chk("t3_empty", instr_valid, 0);
    cyc(15);
    chk("t3_addr", addr_at(0), 8'h40);
    chk("t3_instr", got_at(0), 16'h1040);

    // redirect coincident with the response
    en = 0; cyc(8);
    flush(8'h00); lat = 2; clearq(); en = 1;
    wait_req(8'h01, "t3b_req1_seen");
    @(posedge clk); #1;
    cyc(1);
    redirect = 1; redirect_addr = 8'h80; clearq();
    cyc(1); redirect = 0;
    cyc(12);
    chk("t3b_addr", addr_at(0), 8'h80);
    chk("t3b_instr", got_at(0), 16'h1080);

    // HALT word at address 3
    en = 0; cyc(8);
    flush(8'h00); lat = 1; halt_addr = 3; clearq(); instr_ready = 1; en = 1;
    cyc(20);
    chk("t4_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("t4_instr", got_at(i), 32'h1000 + i);
    chk("t4_halted", halted, 1);
    chk("t4_reqs", addr_q.size(), 4);
    addr_q.delete(); cyc(10);
    chk("t4_no_req", addr_q.size(), 0);
    clearq(); flush(8'h10);
    chk("t4_unhalt", halted, 0);
    cyc(10);
    chk("t4_addr", addr_at(0), 8'h10);
    chk("t4_instr_resume", got_at(0), 16'h1010);
    halt_addr = -1;

    // async reset in WAIT with two entries queued
    en = 0; instr_ready = 0; cyc(4);
    flush(8'h00); lat = 3; en = 1;
    begin
      bit hit = 0;
      for (int i = 0; i < 80 && !hit; i++) begin
        @(negedge clk);
        if (m_q.size() == 2 && m_busy && pend_cnt == 2) hit = 1;
      end
      chk("t5_setup", hit, 1);
    end
    #1 rst = 1; en = 0;
    #1;
    chk("t5_rst_req", imem_req, 0);
    chk("t5_rst_addr", imem_addr, RESET_PC);
    chk("t5_rst_instr", instr, 16'h0000);
    chk("t5_rst_valid", instr_valid, 0);
    chk("t5_rst_halted", halted, 0);
`ifdef FETCH_PERF_EN
    chk("t5_rst_count", fetch_count, 0);
`endif
    @(posedge clk); #1 rst = 0;
    cyc(6);
    chk("t5_late_ignored", instr_valid, 0);
    clearq(); en = 1;
    cyc(20);
    chk("t5_first_addr", addr_at(0), RESET_PC);
    instr_ready = 1; cyc(3); instr_ready = 0; cyc(2);
    chk("t5_accepts", got_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("t5_instr", got_at(i), 32'h1000 + i);
`ifdef FETCH_PERF_EN
    chk("t5_fetch_count", fetch_count, 3);
`endif
    en = 0; cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
